// File: rtl/fifo_rd_stream.sv
// Pulls words from a FIFO read port (1-cycle read latency) into a 2-entry
// skid buffer that drives a valid/ready stream. An optional sequence checker watches captured words.
module fifo_rd_stream #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    output logic          fifo_r_en,
    input  logic [DW-1:0] fifo_data_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    input  logic          chk_en,
    input  logic          chk_load,
    input  logic [DW-1:0] chk_start,
    output logic          chk_err,
    output logic [7:0]    err_count,
    output logic [15:0]   rd_count
);
    logic [DW-1:0] slot0, slot1;
    logic [1:0]    buf_cnt;
    logic          inflight;
    logic          rd_hold;
    logic          pop;
    logic          capture;
    logic [2:0]    occ;
    logic [DW-1:0] exp_val;

    assign pop     = m_valid && m_ready;
    assign capture = inflight;
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = slot0;

    // Words already committed (buffered or in flight) after this cycle's pop must leave room.
    always_comb begin
        occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        fifo_r_en = !rst && !rd_hold && !fifo_empty && (occ < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0     <= '0;
            slot1     <= '0;
            buf_cnt   <= 2'd0;
            inflight  <= 1'b0;
            rd_hold   <= 1'b1;
            exp_val   <= '0;
            chk_err   <= 1'b0;
            err_count <= 8'd0;
            rd_count  <= 16'd0;
        end else begin
            rd_hold  <= 1'b0;
            inflight <= fifo_r_en;

            case ({capture, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) slot0 <= fifo_data_out;
                    else                 slot1 <= fifo_data_out;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    slot0   <= slot1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Shift and append in one step so ordering holds at full rate.
                    if (buf_cnt == 2'd1) begin
                        slot0 <= fifo_data_out;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fifo_data_out;
                    end
                end
                default: ;
            endcase

            if (pop) rd_count <= rd_count + 16'd1;

            // A same-cycle load wins, but the capture is still judged against the old value.
            if (chk_load)     exp_val <= chk_start;
            else if (capture) exp_val <= fifo_data_out + DW'(1);

            if (capture && chk_en && (fifo_data_out != exp_val)) begin
                chk_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a FIFO model feeds the DUT, words read are queued as
// expected output, and a negedge monitor checks stream data, gating and checker results.
module tb_fifo_rd_stream;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data_out = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          chk_en = 1'b0;
    logic          chk_load = 1'b0;
    logic [DW-1:0] chk_start = '0;
    logic          chk_err;
    logic [7:0]    err_count;
    logic [15:0]   rd_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] push_q[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic          take = 1'b0;

    logic [DW-1:0] mdl_exp = '0;
    int            mdl_err = 0;
    logic          mdl_flag = 1'b0;
    logic [15:0]   mdl_rd = '0;
    int            reads = 0;
    int            dlv = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    fifo_rd_stream #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_data_out(fifo_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .chk_en(chk_en), .chk_load(chk_load), .chk_start(chk_start),
        .chk_err(chk_err), .err_count(err_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #950000;
        $display("FAIL watchdog: cycles=%0d want finish before limit", cyc);
        $fatal(1, "watchdog");
    end

    // FIFO model: data for a read strobe appears just after the next rising edge.
    always @(posedge clk) begin
        #1;
        while (push_q.size() > 0) fq.push_back(push_q.pop_front());
        if (take && fq.size() > 0) begin
            fifo_data_out = fq.pop_front();
            exp_q.push_back(fifo_data_out);
        end
        fifo_empty = (fq.size() == 0);
    end

    // Monitor / reference model.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        int            pop_now;
        take = fifo_r_en;
        if (rst) begin
            exp_q.delete();
            mdl_exp = '0; mdl_err = 0; mdl_flag = 1'b0; mdl_rd = '0;
            reads = 0; dlv = 0; hold_prev = 1'b0;
        end else begin
            pop_now = (m_valid && m_ready) ? 1 : 0;
            if (fifo_r_en) begin
                total++;
                if (fifo_empty || (reads - dlv - pop_now) >= 2) begin
                    bad++;
                    $display("FAIL rd_gate: empty=%0b outstanding=%0d want empty=0 outstanding<2",
                             fifo_empty, reads - dlv - pop_now);
                end
            end
            if (hold_prev) begin
                total++;
                if (!m_valid || m_data !== data_prev) begin
                    bad++;
                    $display("FAIL hold: valid=%0b data=%0h want valid=1 data=%0h", m_valid, m_data, data_prev);
                end
            end
            if (chk_load) mdl_exp = chk_start;
            if (pop_now != 0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got %0h want no word", m_data);
                end else begin
                    w = exp_q.pop_front();
                    if (m_data !== w) begin
                        bad++;
                        $display("FAIL data: got %0h want %0h", m_data, w);
                    end
                    if (chk_en && w != mdl_exp) begin
                        mdl_flag = 1'b1;
                        if (mdl_err < 255) mdl_err++;
                    end
                    mdl_exp = w + 8'd1;
                end
                mdl_rd = mdl_rd + 16'd1;
                dlv++;
            end
            if (fifo_r_en) reads++;
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_exp(input logic [DW-1:0] v);
        chk_start = v;
        chk_load  = 1'b1;
        tick();
        chk_load  = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int quiet = 0;
        for (int i = 0; i < max_cyc && quiet < 3; i++) begin
            @(negedge clk);
            if (push_q.size() == 0 && fq.size() == 0 && exp_q.size() == 0 && !m_valid && !fifo_r_en)
                quiet++;
            else
                quiet = 0;
        end
        if (quiet < 3) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size() + fq.size());
        end
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r_en"},    32'(fifo_r_en), 32'd0);
        check({tag, "_valid"},   32'(m_valid),   32'd0);
        check({tag, "_data"},    32'(m_data),    32'd0);
        check({tag, "_chk_err"}, 32'(chk_err),   32'd0);
        check({tag, "_errcnt"},  32'(err_count), 32'd0);
        check({tag, "_rdcnt"},   32'(rd_count),  32'd0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_err_model"}, 32'(err_count), 32'(mdl_err));
        check({tag, "_flag_model"}, 32'(chk_err), 32'(mdl_flag));
        check({tag, "_rd_model"},  32'(rd_count),  32'(mdl_rd));
    endtask

    initial begin
        int c0, c1, n;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;

        // Streaming at full rate with sequence checking.
        tick();
        load_exp(8'hA0);
        chk_en  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_q.push_back(8'(8'hA0 + i));
        c0 = -1; c1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_r_en) begin c0 = cyc; break; end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) begin c1 = cyc; break; end
        end
        check("first_latency", 32'(c1 - c0), 32'd2);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_valid) n++;
        end
        check("stream_consecutive", 32'(n), 32'd15);
        drain(100);
        check("stream_rdcnt", 32'(rd_count), 32'd16);
        check("stream_chk_err", 32'(chk_err), 32'd0);
        check_model("stream");

        // Checker: one mismatch then resync, then saturation.
        load_exp(8'h10);
        push_q.push_back(8'h10); push_q.push_back(8'h11);
        push_q.push_back(8'h55); push_q.push_back(8'h56);
        drain(100);
        check("chk_errcnt", 32'(err_count), 32'd1);
        check("chk_flag",   32'(chk_err),   32'd1);
        check_model("chk");
        for (int i = 0; i < 300; i++) push_q.push_back(8'h33);
        drain(1000);
        check("chk_sat", 32'(err_count), 32'd255);
        check_model("sat");

        // Backpressure with random ready and a 10-cycle stall.
        chk_en = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) push_q.push_back(8'($urandom));
        for (int i = 0; i < 80; i++) begin
            if (i >= 10 && i < 20) m_ready = 1'b0;
            else                   m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        drain(200);
        check_model("bp");

        // Empty FIFO: no reads, no output; then a single word.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("empty_r_en", 32'(fifo_r_en), 32'd0);
            check("empty_valid", 32'(m_valid), 32'd0);
        end
        tick();
        push_q.push_back(8'h5A);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_r_en) n++;
        end
        check("single_read", 32'(n), 32'd1);
        drain(50);

        // Reset during a read burst: the in-flight word is discarded.
        for (int i = 0; i < 20; i++) push_q.push_back(8'(8'h40 + i));
        c0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_r_en) begin c0 = cyc; break; end
        end
        check("mid_rst_saw_read", 32'(c0 >= 0), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_zero("mid_rst");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_r_en", 32'(fifo_r_en), 32'd0);
        tick();
        drain(200);
        check("restart_rdcnt", 32'(rd_count), 32'd19);
        check_model("restart");

        // rd_count wraps after 65536 deliveries.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 65537; i++) push_q.push_back(8'(i));
        drain(70000);
        check("wrap_rdcnt", 32'(rd_count), 32'd1);
        check_model("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
